bundle_frame_serializer: RTL and testbench
==========================================

# bundle_frame_serializer

Schedules the 126-bit packed bundle-vector frame (two 63-bit elements, each `{a, bar_c_1, bar_d_1, bar_c_0, bar_d_0, b}`) from two requesters onto one narrow output stream. Round-robin arbitration picks a source, the block latches its frame, then emits it as LSB-first beats with valid/ready and a last flag. It sits between the frame packers and the shared narrow link.

## Interface
- `FRAME_W`, default 126: packed frame width; fixed by the bundle layout.
- `BEAT_W`, default 32: output beat width; beats per frame `NBEATS = ceil(FRAME_W/BEAT_W)` = 4.
- `clock` input 1: single clock; all state on rising edge.
- `reset_n` input 1: reset, asynchronous assert, active-low.
- `req0_valid` input 1: source 0 frame offered.
- `req0_ready` output 1: source 0 frame accepted this cycle.
- `req0_frame` input FRAME_W: source 0 packed frame.
- `req1_valid` input 1: source 1 frame offered.
- `req1_ready` output 1: source 1 frame accepted this cycle.
- `req1_frame` input FRAME_W: source 1 packed frame.
- `out_valid` output 1: beat valid.
- `out_ready` input 1: sink accepts beat.
- `out_data` output BEAT_W: current beat.
- `out_last` output 1: final beat of the frame.
- `out_src` output 1: source index of the frame being sent.
- `busy` output 1: high in SEND.

## Operation
- Frame layout, element 0 in LSBs: `b_0 [10:0]`, `bar_d_0_0 [30:11]`, `bar_c_0_0 [31]`, `bar_d_0_1 [51:32]`, `bar_c_0_1 [52]`, `a_0 [62:53]`; element 1 is the same pattern at `+63`, so `a_1` is at `[125:116]`.
- FSM with two states: IDLE and SEND.
- IDLE, arbitration is combinational:
  - one valid: grant it;
  - both valid: grant `ptr`;
  - none valid: both readies 0.
- `reqX_ready = (state==IDLE) && any_valid && (grant==X)`.
  - `reqX_ready` does not depend on `out_ready`.
- On accept: latch the frame, zero-extended to `NBEATS*BEAT_W` (128 bits), into a shift register.
  - Set `out_src = grant` and `ptr = ~grant`.
  - Set `beat_cnt = 0` and go to SEND.
- SEND outputs:
  - `out_valid = 1`;
  - `out_data = shreg[BEAT_W-1:0]`;
  - `out_last = (beat_cnt == NBEATS-1)`.
- On `out_valid && out_ready`:
  - not last beat: shift `shreg` right by BEAT_W and increment `beat_cnt`;
  - last beat: return to IDLE.
- `out_valid` low: `out_last` is 0 and `out_data` holds its last value.
- `ptr` changes only on accept.
  - Source 0 has priority on the first contested grant after reset.
- Requesters hold `valid` and `frame` stable until ready. A valid dropped without ready is not an error; that source is simply not granted.

## Timing
- Reset values: state IDLE, `ptr` 0, `beat_cnt` 0, `shreg` 0.
  - Outputs reset to 0: `out_valid`, `out_last`, `out_src`, `busy`, `out_data`.
- Accept at cycle T (IDLE): `out_valid` is high from T+1 with beat 0.
- With `out_ready` held high:
  - beats appear at T+1..T+4;
  - IDLE at T+5, ready to accept again;
  - 5 cycles per frame, one bubble.
- Backpressure: while `out_ready` is low, `out_data`, `out_last` and `out_src` stay stable.
- A requester asserting valid during SEND waits. It is granted in the first IDLE cycle.
- Reset mid-frame: `out_valid` drops immediately and asynchronously. The frame is discarded; no partial resume.
- Registers: `beat_cnt` is 2 bits; `shreg` is 128 bits; the top 2 bits of the final beat are 0.

## Structure
- Package `bundle_frame_pkg`:
  - `FRAME_W`, `ELEM_W` = 63, `BEAT_W`, `NBEATS`;
  - field offset/width constants for `a`, `bar_c`, `bar_d`, `b`;
  - FSM state enum.
- One sub-module, `rr_arbiter_2`: inputs are two valids and `ptr`; outputs are grant and any_valid, purely combinational. The `ptr` register stays in the top level.

## Test plan
- Single frame, `[31:0]=32'h11111111`, `[63:32]=32'h22222222`, `[95:64]=32'h33333333`, `[125:96]=30'h04444444`, from source 1, `out_ready=1`:
  - beats `11111111`, `22222222`, `33333333`, `04444444` on consecutive cycles;
  - `out_last` only on the 4th beat;
  - `out_src=1`.
- Field check: frame with only `b_0=11'h7FF` and `bar_c_0_0=1` -> beat 0 is `32'h800007FF`, beats 1..3 are 0.
- Both valid continuously, 4 frames:
  - grants alternate 0,1,0,1;
  - each `reqX_ready` is a 1-cycle pulse;
  - frames are 5 cycles apart.
- `out_ready` toggled 1,0,0,1,... during a frame:
  - no beat is dropped or duplicated;
  - `out_data` is stable while `out_ready` is low.
- `reset_n` low during beat 2:
  - `out_valid` is 0 the same cycle and `busy` is 0;
  - after release, `ptr=0`, and a contested request grants source 0.
- `req0_valid` raised during SEND: no `req0_ready` until IDLE, then granted on the first IDLE cycle.

Source files
------------

// File: rtl/bundle_frame_pkg.sv
// Shared constants, field layout and FSM state type for the bundle frame serializer.
package bundle_frame_pkg;

   localparam int unsigned FRAME_W = 126;
   localparam int unsigned ELEM_W  = 63;
   localparam int unsigned BEAT_W  = 32;
   localparam int unsigned NBEATS  = (FRAME_W + BEAT_W - 1) / BEAT_W;

   // Field layout inside one 63-bit element; element 1 sits at +ELEM_W.
   localparam int unsigned B_OFF      = 0;
   localparam int unsigned B_W        = 11;
   localparam int unsigned BAR_D0_OFF = 11;
   localparam int unsigned BAR_C0_OFF = 31;
   localparam int unsigned BAR_D1_OFF = 32;
   localparam int unsigned BAR_C1_OFF = 52;
   localparam int unsigned BAR_D_W    = 20;
   localparam int unsigned BAR_C_W    = 1;
   localparam int unsigned A_OFF      = 53;
   localparam int unsigned A_W        = 10;

   function automatic int unsigned field_pos(input int unsigned elem,
                                             input int unsigned field_off);
      return elem * ELEM_W + field_off;
   endfunction

   typedef enum logic [0:0] {
      StIdle,
      StSend
   } state_e;

endpackage

// File: rtl/bundle_frame_serializer_rr_arbiter_2.sv
// Two-way round-robin arbiter; purely combinational, pointer register lives in the caller.
module rr_arbiter_2 (
   input  logic valid0,
   input  logic valid1,
   input  logic ptr,
   output logic grant,
   output logic any_valid
);

   always_comb begin
      any_valid = valid0 | valid1;
      if (valid0 && valid1) begin
         grant = ptr;
      end else begin
         grant = valid1;
      end
   end

endmodule

// File: rtl/bundle_frame_serializer.sv
// Arbitrates two frame sources, latches the winner and streams it LSB-first as narrow beats.
module bundle_frame_serializer #(
   parameter int unsigned FRAME_W = bundle_frame_pkg::FRAME_W,
   parameter int unsigned BEAT_W  = bundle_frame_pkg::BEAT_W
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               req0_valid,
   output logic               req0_ready,
   input  logic [FRAME_W-1:0] req0_frame,
   input  logic               req1_valid,
   output logic               req1_ready,
   input  logic [FRAME_W-1:0] req1_frame,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [BEAT_W-1:0]  out_data,
   output logic               out_last,
   output logic               out_src,
   output logic               busy
);

   import bundle_frame_pkg::*;

   localparam int unsigned NBEATS_L = (FRAME_W + BEAT_W - 1) / BEAT_W;
   localparam int unsigned SHREG_W  = NBEATS_L * BEAT_W;
   localparam int unsigned CNT_W    = (NBEATS_L > 1) ? $clog2(NBEATS_L) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS_L - 1);

   state_e             state_q;
   logic               ptr_q;
   logic [CNT_W-1:0]   beat_cnt_q;
   logic [SHREG_W-1:0] shreg_q;
   logic               out_src_q;

   logic               grant;
   logic               any_valid;
   logic               accept;
   logic [SHREG_W-1:0] frame_ext;

   rr_arbiter_2 u_arb (
      .valid0    (req0_valid),
      .valid1    (req1_valid),
      .ptr       (ptr_q),
      .grant     (grant),
      .any_valid (any_valid)
   );

   always_comb begin
      accept     = (state_q == StIdle) && any_valid;
      req0_ready = accept && !grant;
      req1_ready = accept && grant;
      frame_ext  = '0;
      frame_ext[FRAME_W-1:0] = grant ? req1_frame : req0_frame;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         ptr_q      <= 1'b0;
         beat_cnt_q <= '0;
         shreg_q    <= '0;
         out_src_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (any_valid) begin
                  shreg_q    <= frame_ext;
                  out_src_q  <= grant;
                  ptr_q      <= ~grant;
                  beat_cnt_q <= '0;
                  state_q    <= StSend;
               end
            end
            StSend: begin
               if (out_ready) begin
                  // Final beat is left in place so out_data holds it while idle.
                  if (beat_cnt_q == LAST_BEAT) begin
                     state_q <= StIdle;
                  end else begin
                     shreg_q    <= shreg_q >> BEAT_W;
                     beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      busy      = (state_q == StSend);
      out_valid = busy;
      out_last  = busy && (beat_cnt_q == LAST_BEAT);
      out_data  = shreg_q[BEAT_W-1:0];
      out_src   = out_src_q;
   end

endmodule

// File: tb/tb_bundle_frame_serializer.sv
// Directed self-checking bench for bundle_frame_serializer.
module tb_bundle_frame_serializer;

   import bundle_frame_pkg::*;

   logic         clock = 1'b0;
   logic         reset_n = 1'b0;
   logic         req0_valid = 1'b0;
   logic         req0_ready;
   logic [125:0] req0_frame = '0;
   logic         req1_valid = 1'b0;
   logic         req1_ready;
   logic [125:0] req1_frame = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [31:0]  out_data;
   logic         out_last;
   logic         out_src;
   logic         busy;

   int total = 0;
   int bad   = 0;

   bundle_frame_serializer dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_frame (req0_frame),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_frame (req1_frame),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .out_src    (out_src),
      .busy       (busy)
   );

   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] beat_of(input logic [125:0] f, input int i);
      logic [127:0] ext;
      ext = {2'b00, f};
      return ext[i*32 +: 32];
   endfunction

   task automatic test_reset;
      reset_n = 1'b0;
      #2;
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0 || out_src !== 1'b0) begin
         bad++;
         $display("FAIL reset_ctrl: got valid=%0b busy=%0b last=%0b src=%0b want all 0",
                  out_valid, busy, out_last, out_src);
      end
      total++;
      if (out_data !== 32'h0) begin
         bad++;
         $display("FAIL reset_data: got %h want 00000000", out_data);
      end
      @(negedge clock);
      reset_n = 1'b1;
      tick();
      total++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL idle_no_req: got r0=%0b r1=%0b valid=%0b want 0 0 0",
                  req0_ready, req1_ready, out_valid);
      end
   endtask

   task automatic test_single_frame;
      logic [125:0]      f;
      logic [3:0][31:0]  exp;
      f   = {30'h04444444, 32'h33333333, 32'h22222222, 32'h11111111};
      exp = {32'h04444444, 32'h33333333, 32'h22222222, 32'h11111111};
      out_ready  = 1'b1;
      req1_frame = f;
      req1_valid = 1'b1;
      #1;
      total++;
      if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
         bad++;
         $display("FAIL single_grant: got r0=%0b r1=%0b want 0 1", req0_ready, req1_ready);
      end
      tick();
      req1_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (out_valid !== 1'b1 || out_data !== exp[i] || out_last !== (i == 3) ||
             out_src !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_beat%0d: got v=%0b d=%h l=%0b s=%0b want 1 %h %0b 1",
                     i, out_valid, out_data, out_last, out_src, exp[i], (i == 3));
         end
         tick();
      end
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0 || out_data !== 32'h04444444)
      begin
         bad++;
         $display("FAIL single_idle: got v=%0b b=%0b l=%0b d=%h want 0 0 0 04444444",
                  out_valid, busy, out_last, out_data);
      end
   endtask

   task automatic test_field_check;
      logic [125:0]     f;
      logic [3:0][31:0] exp;
      f = '0;
      f[field_pos(0, B_OFF) +: B_W] = 11'h7FF;
      f[field_pos(0, BAR_C0_OFF)]   = 1'b1;
      exp = {32'h0, 32'h0, 32'h0, 32'h800007FF};
      req0_frame = f;
      req0_valid = 1'b1;
      tick();
      req0_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (out_valid !== 1'b1 || out_data !== exp[i] || out_src !== 1'b0) begin
            bad++;
            $display("FAIL field_beat%0d: got v=%0b d=%h s=%0b want 1 %h 0",
                     i, out_valid, out_data, out_src, exp[i]);
         end
         tick();
      end
   endtask

   task automatic test_back_to_back;
      logic [1:0] exp_rdy;
      logic       exp_src;
      reset_n = 1'b0;
      #3;
      @(negedge clock);
      reset_n = 1'b1;
      tick();
      req0_frame = {30'h0A0A0A0A, 32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1};
      req1_frame = {30'h0B0B0B0B, 32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1};
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      out_ready  = 1'b1;
      for (int cyc = 0; cyc < 20; cyc++) begin
         #1;
         exp_src = ((cyc / 5) % 2) == 1;
         exp_rdy = (cyc % 5 != 0) ? 2'b00 : (exp_src ? 2'b10 : 2'b01);
         total++;
         if ({req1_ready, req0_ready} !== exp_rdy) begin
            bad++;
            $display("FAIL b2b_ready cyc%0d: got %b want %b", cyc, {req1_ready, req0_ready},
                     exp_rdy);
         end
         if (cyc % 5 != 0) begin
            total++;
            if (out_valid !== 1'b1 || out_src !== exp_src ||
                out_data !== beat_of(exp_src ? req1_frame : req0_frame, cyc % 5 - 1)) begin
               bad++;
               $display("FAIL b2b_beat cyc%0d: got v=%0b s=%0b d=%h want 1 %0b %h", cyc,
                        out_valid, out_src, out_data, exp_src,
                        beat_of(exp_src ? req1_frame : req0_frame, cyc % 5 - 1));
            end
         end
         tick();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic test_backpressure;
      logic [125:0] f;
      logic [11:0]  pat;
      int           idx;
      int           k;
      f   = {30'h0C0FFEE0, 32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF};
      pat = 12'b000001101001;
      req0_frame = f;
      req0_valid = 1'b1;
      tick();
      req0_valid = 1'b0;
      idx = 0;
      k   = 0;
      while (idx < 4 && k < 12) begin
         total++;
         if (out_valid !== 1'b1 || out_data !== beat_of(f, idx) || out_last !== (idx == 3) ||
             out_src !== 1'b0) begin
            bad++;
            $display("FAIL bp_beat k%0d: got v=%0b d=%h l=%0b s=%0b want 1 %h %0b 0", k,
                     out_valid, out_data, out_last, out_src, beat_of(f, idx), (idx == 3));
         end
         out_ready = pat[k];
         tick();
         if (pat[k]) idx++;
         k++;
      end
      out_ready = 1'b1;
      total++;
      if (idx != 4 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL bp_done: got beats=%0d valid=%0b want 4 0", idx, out_valid);
      end
   endtask

   task automatic test_reset_mid_frame;
      logic [125:0] f;
      f = {30'h05555555, 32'h66666666, 32'h77777777, 32'h88888888};
      out_ready  = 1'b1;
      req0_frame = f;
      req0_valid = 1'b1;
      tick();
      req0_valid = 1'b0;
      tick();
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== 32'h66666666) begin
         bad++;
         $display("FAIL rst_pre_beat2: got v=%0b d=%h want 1 66666666", out_valid, out_data);
      end
      #2;
      reset_n = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
         bad++;
         $display("FAIL rst_async: got v=%0b b=%0b l=%0b want 0 0 0", out_valid, busy, out_last);
      end
      @(negedge clock);
      reset_n = 1'b1;
      tick();
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      total++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         bad++;
         $display("FAIL rst_ptr_grant: got r0=%0b r1=%0b want 1 0", req0_ready, req1_ready);
      end
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      total++;
      if (out_src !== 1'b0 || out_data !== 32'h88888888) begin
         bad++;
         $display("FAIL rst_restart: got s=%0b d=%h want 0 88888888", out_src, out_data);
      end
      repeat (4) tick();
   endtask

   task automatic test_wait_in_send;
      logic [125:0] e;
      e = {30'h01010101, 32'h02020202, 32'h03030303, 32'h0E0E0E0E};
      out_ready  = 1'b1;
      req1_frame = {30'h0, 32'h0, 32'h0, 32'h5A5A5A5A};
      req1_valid = 1'b1;
      tick();
      req1_valid = 1'b0;
      req0_frame = e;
      req0_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++;
         if (req0_ready !== 1'b0 || out_src !== 1'b1 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL wait_send%0d: got r0=%0b s=%0b v=%0b want 0 1 1", i, req0_ready,
                     out_src, out_valid);
         end
         tick();
      end
      #1;
      total++;
      if (req0_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL wait_idle_grant: got r0=%0b v=%0b want 1 0", req0_ready, out_valid);
      end
      tick();
      req0_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_src !== 1'b0 || out_data !== 32'h0E0E0E0E) begin
         bad++;
         $display("FAIL wait_start: got v=%0b s=%0b d=%h want 1 0 0e0e0e0e", out_valid, out_src,
                  out_data);
      end
      repeat (4) tick();
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_field_check();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_frame();
      test_wait_in_send();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
